// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Declarations shared by the control unit and the multiplier:
//   ALU_MUL / ALU_MULH / ALU_MULHU : aluop encodings for the multiply group
//   mul_state_e                    : multiplier sequencer states
//   is_mul_op()                    : true for any aluop the multiplier accepts
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [3:0] ALU_MUL   = 4'b0101;
   localparam logic [3:0] ALU_MULH  = 4'b0110;
   localparam logic [3:0] ALU_MULHU = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
   endfunction

endpackage

// File: rtl/mul_unit_if.sv
// -----------------------------------------------------------------------------
// mul_unit_if
// Request/response bundle between the pipeline and the multiplier.
//   start, aluop, a, b         : request (pipeline -> multiplier)
//   busy, stall, done, result  : status and product (multiplier -> pipeline)
// master = pipeline side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface mul_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [3:0]      aluop;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, aluop, a, b,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, aluop, a, b,
      output busy, stall, done, result
   );
endinterface

// File: rtl/mul_core.sv
// -----------------------------------------------------------------------------
// mul_core
// Iterative radix-2 shift-add multiplier on unsigned XLEN-bit operands.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture mcand/mplier and clear the accumulator
//   step         : perform one shift-add step
//   mcand/mplier : unsigned operands (magnitudes)
//   prod_next    : accumulator value after the current step; after the step
//                  taken while last=1 it is the complete 2*XLEN-bit product
//   last         : the step in progress is the final one
// -----------------------------------------------------------------------------
module mul_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [XLEN-1:0]   mcand,
   input  logic [XLEN-1:0]   mplier,
   output logic [2*XLEN-1:0] prod_next,
   output logic              last
);
   logic [5:0]        count_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [2*XLEN-1:0] mcand_reg;
   logic [XLEN-1:0]   mplier_reg;

   assign prod_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign last      = (count_reg == 6'(XLEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= '0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
      end else if (load) begin
         count_reg  <= '0;
         acc_reg    <= '0;
         mcand_reg  <= {{XLEN{1'b0}}, mcand};
         mplier_reg <= mplier;
      end else if (step) begin
         count_reg  <= count_reg + 6'd1;
         acc_reg    <= prod_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
      end
   end
endmodule

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
// RISC-V M-extension multiplier (mul / mulh / mulhu) with a start/done
// handshake and a pipeline stall request.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_unit_if.slave (start, aluop, a, b -> busy, stall, done, result)
// Build option MUL_UNIT_FAST_EN: when defined, the full product is formed
// combinationally at acceptance and the unit goes IDLE->DONE in one edge.
// Otherwise mul_core iterates one bit per cycle (done XLEN+1 edges after
// the accepting edge, inclusive).
// -----------------------------------------------------------------------------
import riscv_pkg::*;

module mul_unit #(
   parameter int XLEN = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   mul_unit_if.slave bus
);
   localparam int PW = 2 * XLEN;

   mul_state_e      state_reg, state_next;
   logic            accept;
   logic            run_last;
   logic            result_load;
   logic            busy_c, stall_c, done_c;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN-1:0] result_reg;
   logic [PW-1:0]   prod_signed;
   logic [3:0]      sel_op;

   assign accept = (state_reg == IDLE) && bus.start && is_mul_op(bus.aluop);

   // Only mulh is signed. Magnitudes are taken as unsigned XLEN values, so the
   // most negative operand negates to itself and still reads as 2^(XLEN-1).
   assign a_neg = (bus.aluop == ALU_MULH) && bus.a[XLEN-1];
   assign b_neg = (bus.aluop == ALU_MULH) && bus.b[XLEN-1];
   assign a_mag = a_neg ? -bus.a : bus.a;
   assign b_mag = b_neg ? -bus.b : bus.b;

`ifdef MUL_UNIT_FAST_EN
   localparam mul_state_e ACCEPT_NEXT = DONE;

   logic [PW-1:0] prod_mag;

   assign prod_mag    = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
   assign prod_signed = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
   assign sel_op      = bus.aluop;
   assign result_load = accept;
   assign run_last    = 1'b0;
`else
   localparam mul_state_e ACCEPT_NEXT = RUN;

   logic [3:0]    op_reg;
   logic          neg_reg;
   logic [PW-1:0] prod_next;
   logic          last;

   mul_core #(.XLEN(XLEN)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .step      (state_reg == RUN),
      .mcand     (a_mag),
      .mplier    (b_mag),
      .prod_next (prod_next),
      .last      (last)
   );

   // Sign correction is applied to the value the final step produces, so the
   // result register is loaded on the same edge that enters DONE.
   assign prod_signed = neg_reg ? -prod_next : prod_next;
   assign sel_op      = op_reg;
   assign result_load = (state_reg == RUN) && last;
   assign run_last    = last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg  <= '0;
         neg_reg <= 1'b0;
      end else if (accept) begin
         op_reg  <= bus.aluop;
         neg_reg <= a_neg ^ b_neg;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         result_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (result_load) begin
            result_reg <= (sel_op == ALU_MUL) ? prod_signed[XLEN-1:0]
                                              : prod_signed[PW-1:XLEN];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      busy_c     = 1'b0;
      stall_c    = 1'b0;
      done_c     = 1'b0;
      case (state_reg)
         IDLE: begin
            stall_c = accept;
            if (accept) state_next = ACCEPT_NEXT;
         end
         RUN: begin
            busy_c  = 1'b1;
            stall_c = 1'b1;
            if (run_last) state_next = DONE;
         end
         DONE: begin
            busy_c     = 1'b1;
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy   = busy_c;
   assign bus.stall  = stall_c;
   assign bus.done   = done_c;
   assign bus.result = result_reg;
endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
// Self-checking bench for mul_unit (XLEN=32): directed corner cases, an
// ignored restart, a mid-operation reset, an illegal aluop and a randomized
// sweep, all compared against a 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
import riscv_pkg::*;

module tb_mul_unit;
`ifdef MUL_UNIT_FAST_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 33;
`endif
   localparam int RST_EDGE = (LAT > 10) ? 10 : 0;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   mul_unit_if #(.XLEN(32)) bus ();

   mul_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      longint      sp;
      logic [63:0] up;
      sp = longint'($signed(x)) * longint'($signed(y));
      up = {32'b0, x} * {32'b0, y};
      case (op)
         ALU_MUL:  return up[31:0];
         ALU_MULH: return sp[63:32];
         default:  return up[63:32];
      endcase
   endfunction

   // One complete operation; optionally fires a second start mid-run.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input bit restart);
      logic [31:0] expv, got;
      int          done_edge, ndone;
      bit          busy_ok, stall_ok;
      expv      = ref_mul(op, av, bv);
      got       = '0;
      done_edge = 0;
      ndone     = 0;
      busy_ok   = 1'b1;
      stall_ok  = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.aluop = op; bus.a = av; bus.b = bv;
      #1 chk({tag, "/stall_acc"}, 64'(bus.stall), 64'd1);
      for (int e = 1; e <= LAT + 3; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            bus.start = 1'b0;
            bus.a     = $urandom;
            bus.b     = $urandom;
         end
         if (restart && LAT > 6 && e == 5) begin
            bus.start = 1'b1; bus.aluop = ALU_MUL;
            bus.a = av ^ 32'h1234_5677; bus.b = bv + 32'd3;
         end
         if (e == 6) bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            done_edge = e;
            got       = bus.result;
         end
         if ((e <= LAT) != bus.busy) busy_ok = 1'b0;
         if ((e < LAT) != bus.stall) stall_ok = 1'b0;
      end
      bus.start = 1'b0;
      chk({tag, "/done_edge"}, 64'(done_edge), 64'(LAT));
      chk({tag, "/ndone"}, 64'(ndone), 64'd1);
      chk({tag, "/result"}, 64'(got), 64'(expv));
      chk({tag, "/hold"}, 64'(bus.result), 64'(expv));
      chk({tag, "/busy_win"}, 64'(busy_ok), 64'd1);
      chk({tag, "/stall_win"}, 64'(stall_ok), 64'd1);
      $display("op %s aluop=%b a=%h b=%h result=%h exp=%h done_edge=%0d",
               tag, op, av, bv, got, expv, done_edge);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] av, bv;
      int          ndone;
      bit          quiet;

      rst_n = 1'b0;
      bus.start = 1'b0; bus.aluop = 4'b0000; bus.a = '0; bus.b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/busy", 64'(bus.busy), 64'd0);
      chk("rst/stall", 64'(bus.stall), 64'd0);
      chk("rst/done", 64'(bus.done), 64'd0);
      chk("rst/result", 64'(bus.result), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      do_op("mul7x6", ALU_MUL, 32'd7, 32'd6, 1'b0);
      do_op("mulh_m1x2", ALU_MULH, 32'hFFFF_FFFF, 32'h2, 1'b0);
      do_op("mulhu_m1x2", ALU_MULHU, 32'hFFFF_FFFF, 32'h2, 1'b0);
      do_op("mulh_min2", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0);
      do_op("mul_min2", ALU_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
      do_op("mul_zero", ALU_MUL, 32'd0, 32'hDEAD_BEEF, 1'b0);
      do_op("restart", ALU_MULH, 32'hFFFF_FFF9, 32'h0012_3456, 1'b1);

      // Reset cutting an in-flight multiply.
      @(negedge clk);
      bus.start = 1'b1; bus.aluop = ALU_MUL; bus.a = 32'd1234; bus.b = 32'd99;
      for (int e = 1; e <= RST_EDGE; e++) begin
         @(posedge clk); #1;
         if (e == 1) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst/busy", 64'(bus.busy), 64'd0);
      chk("midrst/stall", 64'(bus.stall), 64'd0);
      chk("midrst/done", 64'(bus.done), 64'd0);
      chk("midrst/result", 64'(bus.result), 64'd0);
      ndone = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      chk("midrst/no_done", 64'(ndone), 64'd0);
      $display("op midrst reset at edge %0d, dones afterwards=%0d", RST_EDGE, ndone);
      do_op("after_rst", ALU_MUL, 32'd3, 32'd5, 1'b0);

      // Non-multiply aluop must be ignored entirely.
      @(negedge clk);
      bus.start = 1'b1; bus.aluop = 4'b0011; bus.a = 32'd7; bus.b = 32'd6;
      #1 chk("add/stall", 64'(bus.stall), 64'd0);
      quiet = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         if (bus.busy || bus.stall || bus.done) quiet = 1'b0;
      end
      bus.start = 1'b0;
      chk("add/quiet", 64'(quiet), 64'd1);
      chk("add/result_kept", 64'(bus.result), 64'd15);
      $display("op add aluop=0011 ignored quiet=%0d", quiet);

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(2))
            0:       op = ALU_MUL;
            1:       op = ALU_MULH;
            default: op = ALU_MULHU;
         endcase
         av = $urandom;
         bv = $urandom;
         if ($urandom_range(3) == 0) av = 32'h8000_0000;
         if ($urandom_range(3) == 0) bv = 32'hFFFF_FFFF;
         do_op($sformatf("rnd%0d", i), op, av, bv, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply.
REQ-005 SHALL have port aluop, input, 4, operation code from the control unit: 0101 mul, 0110 mulh, 0111 mulhu.
REQ-006 SHALL have ports a and b, input, XLEN each, operands rs1 and rs2.
REQ-007 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-008 SHALL have port stall, output, 1, pipeline hold request.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-010 SHALL have port result, output, XLEN, product selection.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL accept a request only in IDLE with start=1 and aluop in {0101, 0110, 0111}; the accepting edge latches a, b and aluop.
REQ-013 SHALL ignore start in RUN and DONE, and any start with another aluop; these cause no state change and no done.
REQ-014 SHALL perform one radix-2 shift-add step per RUN cycle using a 6-bit counter, then move RUN->DONE after exactly XLEN RUN edges.
REQ-015 SHALL assert done for exactly one cycle while in DONE, then move DONE->IDLE on the next edge.
REQ-016 SHALL assert done on the (XLEN+1)th rising edge counted from and including the accepting edge, which is 33 edges for XLEN=32.
REQ-017 SHALL drive result as product[XLEN-1:0] for mul, signed x signed product[2*XLEN-1:XLEN] for mulh, and unsigned x unsigned product[2*XLEN-1:XLEN] for mulhu.
REQ-018 SHALL compute mulh on operand magnitudes, then negate the 2*XLEN-bit product when the operand signs differ; magnitude 0x80000000 SHALL be handled as unsigned 32-bit.
REQ-019 SHALL hold result stable from DONE until the next accepted request completes.
REQ-020 SHALL drive stall = (state==RUN) | (IDLE & an accepted request), so the consuming instruction is held until done.
REQ-021 SHALL treat a zero operand normally, with no early termination; latency is fixed.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-RUN, immediately enter IDLE and clear counter, operands, product, result, busy, stall and done to 0.
REQ-023 SHALL abandon an in-flight operation cut by reset without ever asserting done for it.

Configuration
REQ-024 SHALL support macro MUL_UNIT_FAST_EN.
REQ-025 With MUL_UNIT_FAST_EN defined, SHALL compute the full product combinationally at acceptance, register it, and go IDLE->DONE directly with done on the 1st edge after acceptance; RUN is unused.
REQ-026 Without MUL_UNIT_FAST_EN, SHALL use the iterative datapath with the latency in REQ-016; results SHALL be identical in both builds.

Structure
REQ-027 SHALL place aluop encodings (ALU_MUL, ALU_MULH, ALU_MULHU) and the state enum in shared package riscv_pkg, which the control unit also uses.
REQ-028 SHALL put the iterative shift-add datapath (counter, partial product, multiplicand shift) in sub-module mul_core; mul_unit holds the FSM, sign handling and result selection.

Verification
REQ-029 SHALL verify: mul with a=7, b=6 -> done on edge 33, result=42, busy high edges 1-33.
REQ-030 SHALL verify: mulh with a=0xFFFFFFFF (-1), b=0x00000002 -> result=0xFFFFFFFF; mulhu with the same operands -> result=0x00000001.
REQ-031 SHALL verify: mulh with a=b=0x80000000 -> result=0x40000000; mul with the same operands -> result=0x00000000.
REQ-032 SHALL verify: start pulsed again during RUN with different operands -> ignored, exactly one done, first result returned.
REQ-033 SHALL verify: rst_n driven low at RUN cycle 10 -> all outputs 0 at once, no done; a fresh mul 3x5 afterwards -> 15.
REQ-034 SHALL verify: start with aluop=0011 (add) -> no busy, no stall, no done; with MUL_UNIT_FAST_EN, mul 7x6 -> done on edge 1, result=42.
